mult_control_param: RTL and testbench

MULT_CONTROL_PARAM -- requirements
Module: mult_control_param

---
 rtl/mult_control_param.sv | 123 ++++++++++++
 tb/tb_mult_control_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mult_control_param.sv
`default_nettype none
// ============================================================================
// Module   : mult_control_param
// Purpose  : Sequencing controller for a shift-add (Booth-style last step)
//            multiplier. Walks WIDTH add/shift iterations, issues the
//            datapath strobes, and holds the result until Run is released.
// Revision : 1.0 - initial release
// ============================================================================
module mult_control_param #(
    parameter int WIDTH = 8,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Run,
    input  logic          ClearA_LoadB,
    input  logic          M,
    input  logic          Signed_mode,
    output logic          Clr_ld,
    output logic          Add,
    output logic          Sub,
    output logic          Shift,
    output logic          Busy,
    output logic          Done,
    output logic [IW-1:0] Iter
);

    // Index of the final (sign) iteration.
    localparam logic [IW-1:0] C_LAST_ITER = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_iter;
    logic          r_sgn;      // signed mode captured at start of multiply
    logic          r_shift;
    logic          r_busy;
    logic          r_done;

    logic          w_last_iter;
    logic          w_in_add;
    logic          w_sub_sel;

    // Sequencer: state, iteration index, latched mode and registered strobes.
    // Busy/Done/Shift are computed from the next state so they are clean
    // register outputs aligned with the state they describe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_iter  <= '0;
            r_sgn   <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Run has priority over ClearA_LoadB here.
                    if (Run) begin
                        r_state <= S_ADD;
                        r_iter  <= '0;
                        r_sgn   <= Signed_mode;
                        r_busy  <= 1'b1;
                    end
                end
                S_ADD: begin
                    r_state <= S_SHIFT;
                    r_shift <= 1'b1;
                end
                S_SHIFT: begin
                    r_shift <= 1'b0;
                    if (r_iter == C_LAST_ITER) begin
                        r_state <= S_HOLD;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_ADD;
                        r_iter  <= r_iter + 1'b1;
                    end
                end
                S_HOLD: begin
                    // Stay here until Run drops so a held Run cannot
                    // retrigger a second multiply.
                    if (!Run) begin
                        r_state <= S_IDLE;
                        r_iter  <= '0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_iter  <= '0;
                    r_shift <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Add/Sub follow the live multiplier bit; the last iteration of a
    // signed multiply subtracts because the MSB carries negative weight.
    always_comb begin
        w_last_iter = (r_iter == C_LAST_ITER);
        w_in_add    = (r_state == S_ADD);
        w_sub_sel   = w_last_iter & r_sgn;
        Add         = w_in_add & M & ~w_sub_sel;
        Sub         = w_in_add & M &  w_sub_sel;
        Clr_ld      = (r_state == S_IDLE) & ClearA_LoadB & ~Run;
    end

    assign Shift = r_shift;
    assign Busy  = r_busy;
    assign Done  = r_done;
    assign Iter  = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_mult_control_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_control_param
// Purpose  : Scoreboard bench for mult_control_param. A timeline model
//            (phase counter since the Run-sampling edge) predicts every
//            cycle's outputs; a monitor compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_control_param;

    localparam int W  = 8;
    localparam int IW = $clog2(W);

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Run = 1'b0;
    logic          ClearA_LoadB = 1'b0;
    logic          M = 1'b0;
    logic          Signed_mode = 1'b0;
    logic          Clr_ld, Add, Sub, Shift, Busy, Done;
    logic [IW-1:0] Iter;

    mult_control_param #(.WIDTH(W), .IW(IW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Signed_mode  (Signed_mode),
        .Clr_ld       (Clr_ld),
        .Add          (Add),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy),
        .Done         (Done),
        .Iter         (Iter)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          clr;
        logic          add;
        logic          sub;
        logic          shift;
        logic          busy;
        logic          done;
        logic [IW-1:0] iter;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: ph = 0 idle, 1..2W = cycles since start, >2W = hold.
    int   ph   = 0;
    logic msgn = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic step_model();
        if (Reset) begin
            ph   = 0;
            msgn = 1'b0;
        end else if (ph == 0) begin
            if (Run) begin
                ph   = 1;
                msgn = Signed_mode;
            end
        end else if (ph <= 2*W) begin
            ph = ph + 1;
        end else if (!Run) begin
            ph = 0;
        end
    endtask

    function automatic obs_t model_out(input logic run, input logic clr, input logic m);
        obs_t e;
        int   it;
        e = '0;
        if (ph == 0) begin
            e.clr = clr & ~run;
        end else if (ph <= 2*W) begin
            e.busy = 1'b1;
            if (ph % 2 == 1) begin
                it     = (ph - 1) / 2;
                e.iter = IW'(it);
                if (it == W-1 && msgn) e.sub = m;
                else                   e.add = m;
            end else begin
                e.shift = 1'b1;
                e.iter  = IW'(ph/2 - 1);
            end
        end else begin
            e.done = 1'b1;
            e.iter = IW'(W-1);
        end
        return e;
    endfunction

    // One clock cycle of stimulus; expected outputs for that cycle are queued.
    task automatic cycle(input logic rst, input logic run, input logic clr,
                         input logic m, input logic sm);
        @(posedge Clk);
        step_model();
        cyc++;
        #1;
        Reset = rst; Run = run; ClearA_LoadB = clr; M = m; Signed_mode = sm;
        if (rst) begin
            ph   = 0;
            msgn = 1'b0;
        end
        exp_q.push_back(model_out(run, clr, m));
    endtask

    // Cycle in which Reset is asserted asynchronously in mid-cycle.
    task automatic cycle_areset(input logic run, input logic clr, input logic m, input logic sm);
        @(posedge Clk);
        step_model();
        cyc++;
        #1;
        Reset = 1'b0; Run = run; ClearA_LoadB = clr; M = m; Signed_mode = sm;
        #2;
        Reset = 1'b1;
        ph    = 0;
        msgn  = 1'b0;
        #1;
        check("areset_busy",  32'(Busy),  32'd0);
        check("areset_iter",  32'(Iter),  32'd0);
        check("areset_shift", 32'(Shift), 32'd0);
        exp_q.push_back(model_out(run, clr, m));
    endtask

    // Monitor: compare one queued expectation per cycle, away from the edge.
    always @(negedge Clk) begin
        obs_t e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{Clr_ld, Add, Sub, Shift, Busy, Done, Iter};
            check("outputs{clr,add,sub,shift,busy,done,iter}", 32'(g), 32'(e));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with ClearA_LoadB high: Clr_ld still follows IDLE rule.
        cycle(1, 0, 1, 1, 1);
        cycle(1, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);
        // Clear/load in IDLE, then Run has priority over ClearA_LoadB.
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 1, 1, 1);
        repeat (2*W + 3) cycle(0, 1, 1, 1, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        // Unsigned run; Signed_mode toggled mid-multiply must not matter.
        cycle(0, 1, 0, 1, 0);
        for (int i = 1; i <= 2*W + 3; i++)
            cycle(0, (i < 4) || (i > 6) ? 1'b1 : 1'b0, 1'b0, 1'b1, (i == 5) ? 1'b1 : 1'b0);
        cycle(0, 0, 0, 0, 0);
        // Async reset in cycle 6 of a run, then no strobes until Run.
        cycle(0, 1, 0, 1, 1);
        repeat (5) cycle(0, 1, 0, 1, 1);
        cycle_areset(1, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        repeat (3) cycle(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1);
        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0)
                cycle_areset($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                             $urandom_range(0, 1), $urandom_range(0, 1));
            else
                cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        end
        cycle(0, 0, 0, 0, 0);
        repeat (2) @(negedge Clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
